// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel-to-serial word transmitter with a one-word holding
// register. Words arrive over valid/ready and leave one bit at a time on tx_sd,
// framed by tx_frame, so the receiving shift-in register can shift while
// tx_frame is high and latch its word when tx_frame falls.
module serial_word_tx #(
    parameter int WIDTH      = 4,
    parameter int MSB_FIRST  = 1,
    parameter int BIT_CYCLES = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic             input_clock1_clk_1,
    input  logic             input_push_button2_rst_n_2,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             tx_sd,
    output logic             tx_frame,
    output logic             tx_done,
    output logic             busy
);

    // Counter widths; a single-cycle count still needs one bit to hold zero.
    localparam int BW = $clog2(WIDTH);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]    cyc_cnt_q, cyc_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic             load;

    logic in_ready_q, in_ready_d;
    logic tx_sd_q, tx_sd_d;
    logic tx_frame_q, tx_frame_d;
    logic tx_done_q, tx_done_d;
    logic busy_q, busy_d;

    // Bit currently presented by the shifter, depending on transmit order.
    function automatic logic out_bit(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    // Shifter contents after the current bit has been sent.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
    endfunction

    // Next-state logic; outputs are derived from the next state so they are
    // registered and line up with the state they describe.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        cyc_cnt_d   = cyc_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        tx_done_d   = 1'b0;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                if (hold_full_q) load = 1'b1;
            end
            SHIFT: begin
                if (cyc_cnt_q == CYC_LAST) begin
                    cyc_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        gap_cnt_d = '0;
                        tx_done_d = 1'b1;
                        state_d   = GAP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shreg_d   = advance(shreg_q);
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    if (hold_full_q) load = 1'b1;
                    else             state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Drain HOLD into the shifter and start a frame.
        if (load) begin
            shreg_d     = hold_q;
            hold_full_d = 1'b0;
            bit_cnt_d   = '0;
            cyc_cnt_d   = '0;
            state_d     = SHIFT;
        end

        // in_ready_q is high only while HOLD is empty, so accept and drain
        // never coincide.
        if (in_valid && in_ready_q) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end

        tx_frame_d = (state_d == SHIFT);
        tx_sd_d    = tx_frame_d & out_bit(shreg_d);
        busy_d     = (state_d != IDLE) | hold_full_d;
        in_ready_d = ~hold_full_d;
    end

    // State, datapath and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge input_clock1_clk_1) begin
        if (!input_push_button2_rst_n_2) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            cyc_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            in_ready_q  <= 1'b1;
            tx_sd_q     <= 1'b0;
            tx_frame_q  <= 1'b0;
            tx_done_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            cyc_cnt_q   <= cyc_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            in_ready_q  <= in_ready_d;
            tx_sd_q     <= tx_sd_d;
            tx_frame_q  <= tx_frame_d;
            tx_done_q   <= tx_done_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready = in_ready_q;
    assign tx_sd    = tx_sd_q;
    assign tx_frame = tx_frame_q;
    assign tx_done  = tx_done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: directed and random checks of serial_word_tx.
// dut0 uses the default configuration and feeds a model shift-in register;
// dut1 is LSB-first with 3 clocks per bit and a 2-clock gap.
module tb_serial_word_tx;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         v0 = 1'b0, v1 = 1'b0;
    logic [W-1:0] d0 = '0, d1 = '0;
    logic         r0, sd0, fr0, dn0, bz0;
    logic         r1, sd1, fr1, dn1, bz1;

    serial_word_tx #(.WIDTH(W), .MSB_FIRST(1), .BIT_CYCLES(1), .GAP_CYCLES(1)) dut0 (
        .input_clock1_clk_1(clk), .input_push_button2_rst_n_2(rst_n),
        .in_valid(v0), .in_data(d0), .in_ready(r0),
        .tx_sd(sd0), .tx_frame(fr0), .tx_done(dn0), .busy(bz0)
    );

    serial_word_tx #(.WIDTH(W), .MSB_FIRST(0), .BIT_CYCLES(3), .GAP_CYCLES(2)) dut1 (
        .input_clock1_clk_1(clk), .input_push_button2_rst_n_2(rst_n),
        .in_valid(v1), .in_data(d1), .in_ready(r1),
        .tx_sd(sd1), .tx_frame(fr1), .tx_done(dn1), .busy(bz1)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [W-1:0] exp_q[$];   // words accepted by dut0, not yet received
    int starts[$];            // cycle index of each dut0 frame start
    int rx_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model receiver: shift MSB-first while tx_frame is high, latch on its fall.
    logic [W-1:0] rx_w = '0;
    int rx_nb = 0;
    logic in_fr = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("done_in_reset", dn0, 0);
            in_fr = 1'b0;
            rx_nb = 0;
        end else begin
            chk("tx_done_pulse", dn0, {31'b0, in_fr & ~fr0});
            if (fr0) begin
                if (!in_fr) starts.push_back(cyc);
                in_fr = 1'b1;
                rx_w  = {rx_w[W-2:0], sd0};
                rx_nb++;
            end else if (in_fr) begin
                in_fr = 1'b0;
                chk("frame_len", rx_nb, W);
                chk("word_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("rx_word", rx_w, exp_q.pop_front());
                rx_cnt++;
                rx_nb = 0;
            end
        end
    end

    // Offer a word at the current negedge and hold it until accepted.
    task automatic send(input int which, input logic [W-1:0] w, output int stalls);
        int n = 0;
        if (which == 0) begin v0 = 1'b1; d0 = w; end
        else            begin v1 = 1'b1; d1 = w; end
        while (((which == 0) ? r0 : r1) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", n < 50, 1);
        if (which == 0 && n < 50) exp_q.push_back(w);
        @(negedge clk);
        if (which == 0) v0 = 1'b0; else v1 = 1'b0;
        stalls = n;
    endtask

    // Wait for dut0 to deliver everything and go idle.
    task automatic drain(input int lim);
        int n = 0;
        while ((exp_q.size() != 0 || bz0 !== 1'b0) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", n < lim, 1);
    endtask

    // dut1 frame: LSB first, each bit held 3 clocks, then a 2-clock gap.
    task automatic frame1(input logic [W-1:0] w);
        for (int i = 0; i < W * 3; i++) begin
            @(negedge clk);
            chk("d1_frame_hi", fr1, 1);
            chk("d1_sd", sd1, w[i / 3]);
        end
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            chk("d1_gap_lo", fr1, 0);
            chk("d1_gap_sd", sd1, 0);
            chk("d1_done", dn1, (g == 0) ? 1 : 0);
        end
        @(negedge clk);
        chk("d1_idle_busy", bz1, 0);
        chk("d1_idle_ready", r1, 1);
    endtask

    initial begin
        int st;
        int base, rc, ns, rx0;
        logic [W-1:0] w;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sd", sd0, 0);
        chk("rst_frame", fr0, 0);
        chk("rst_done", dn0, 0);
        chk("rst_busy", bz0, 0);
        chk("rst_ready", r0, 1);
        chk("rst_d1_ready", r1, 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_frame", fr0, 0);
        chk("idle_busy", bz0, 0);

        // T1: 0xB MSB first
        w = 4'hB;
        send(0, w, st);
        chk("t1_busy", bz0, 1);
        chk("t1_ready", r0, 0);
        chk("t1_prefame", fr0, 0);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("t1_frame", fr0, 1);
            chk("t1_sd", sd0, w[W-1-i]);
        end
        @(negedge clk);
        chk("t1_gap_frame", fr0, 0);
        chk("t1_done", dn0, 1);
        @(negedge clk);
        chk("t1_done_once", dn0, 0);
        chk("t1_busy_end", bz0, 0);
        chk("t1_ready_end", r0, 1);

        // T2: three words offered back to back
        base = starts.size();
        send(0, 4'h5, st);
        send(0, 4'hA, st);
        chk("t2_stall_A", st, 1);
        send(0, 4'hC, st);
        chk("t2_stall_C", st, 4);
        drain(100);
        chk("t2_frames", starts.size() - base, 3);
        if (starts.size() - base == 3) begin
            chk("t2_spacing_1", starts[base+1] - starts[base], W + 1);
            chk("t2_spacing_2", starts[base+2] - starts[base+1], W + 1);
        end

        // T3/T4 on dut1
        send(1, 4'h9, st);
        frame1(4'h9);
        send(1, 4'h1, st);
        frame1(4'h1);

        // T5: reset on the 3rd bit of 0x6 with 0x3 waiting in HOLD
        w = 4'h6;
        send(0, w, st);
        send(0, 4'h3, st);
        chk("t5_bit1", sd0, w[W-2]);
        @(negedge clk);
        chk("t5_frame", fr0, 1);
        chk("t5_bit2", sd0, w[W-3]);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_sd", sd0, 0);
        chk("t5_frame_rst", fr0, 0);
        chk("t5_done", dn0, 0);
        chk("t5_busy", bz0, 0);
        chk("t5_ready", r0, 1);
        exp_q.delete();
        rc = rx_cnt;
        ns = starts.size();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("t5_quiet", fr0, 0);
        end
        chk("t5_no_rx", rx_cnt, rc);
        chk("t5_no_start", starts.size(), ns);
        chk("t5_idle", bz0, 0);

        // T6: random words with random idle spacing
        rx0 = rx_cnt;
        for (int k = 0; k < 2000; k++) begin
            repeat ($urandom_range(0, 3) == 0 ? 1 : 0) @(negedge clk);
            repeat ($urandom_range(0, 1)) @(negedge clk);
            w = W'($urandom);
            send(0, w, st);
        end
        drain(200);
        chk("t6_count", rx_cnt - rx0, 2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
